// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the Fibonacci stack sequencer: the controller state
// encoding, default parameter values and the recursion leaf threshold.
// -----------------------------------------------------------------------------
package fib_pkg;

    // Controller states. IDLE is zero so that the reset value decodes to "no
    // stack activity".
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_PUSH_N = 3'd2,
        ST_EVAL   = 3'd3,
        ST_PUSH1  = 3'd4,
        ST_PUSH2  = 3'd5,
        ST_DONE   = 3'd6
    } fib_state_t;

    // Default sizing. The stack word must be able to hold any accepted n, and
    // the stack (256 deep) must hold n+1 entries, hence N_MAX < 256.
    localparam int FIB_DATA_W = 8;
    localparam int FIB_N_W    = 5;
    localparam int FIB_RES_W  = 16;
    localparam int FIB_N_MAX  = 24;

    // Values below this are leaves of the recursion tree: Fib(0)=0, Fib(1)=1,
    // so the popped value itself is the leaf contribution.
    localparam int FIB_LEAF   = 2;

endpackage : fib_pkg

// File: rtl/fib_stack_ctrl.sv
// -----------------------------------------------------------------------------
// fib_stack_ctrl
// Computes Fibonacci(n) by depth-first expansion of the naive recursion tree
// using an external LIFO. Each popped value x >= 2 is replaced on the stack by
// x-1 and x-2; each popped leaf (0 or 1) is added to the result accumulator.
// The job ends when the stack runs empty.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start, n          : request pulse and operand, sampled only in IDLE
//   busy              : high from the cycle after acceptance through the
//                       cycle in which done is high
//   done              : one-cycle completion pulse
//   err               : with done, operand was larger than N_MAX
//   ovf               : accumulator wrapped during the job (valid with done)
//   result            : Fibonacci(n) mod 2^RES_W, held until next acceptance
//   stk_push, stk_pop : stack controls, never both high
//   stk_din           : value pushed onto the stack
//   stk_dout          : combinational top-of-stack from the stack
//   stk_empty         : combinational empty flag from the stack
//
// The stack has no reset, so every job first drains whatever it holds.
// -----------------------------------------------------------------------------
module fib_stack_ctrl
    import fib_pkg::*;
#(
    parameter int DATA_W = FIB_DATA_W,
    parameter int N_W    = FIB_N_W,
    parameter int RES_W  = FIB_RES_W,
    parameter int N_MAX  = FIB_N_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_W-1:0]    n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic [RES_W-1:0]  result,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_din,
    input  logic [DATA_W-1:0] stk_dout,
    input  logic              stk_empty
);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    fib_state_t        state_q,    state_d;
    logic [DATA_W-1:0] n_q,        n_d;
    logic [DATA_W-1:0] x_q,        x_d;
    logic [RES_W-1:0]  result_q,   result_d;
    logic              ovf_q,      ovf_d;
    logic              err_flag_q, err_flag_d;
    logic              err_q,      err_d;
    logic              done_q,     done_d;
    logic              busy_q,     busy_d;

    // Accumulator sum with carry; only consulted when the popped value is a
    // leaf, in which case bit 0 of the popped word is the whole value.
    logic [RES_W:0]    sum_s;
    logic              is_leaf_s;
    logic              n_too_big_s;

    // Leaf detection, accumulator adder and range check of the request.
    always_comb begin
        is_leaf_s   = (stk_dout < DATA_W'(FIB_LEAF));
        sum_s       = {1'b0, result_q} + {{RES_W{1'b0}}, stk_dout[0]};
        n_too_big_s = (32'(n) > 32'(N_MAX));
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        x_d        = x_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        err_flag_d = err_flag_q;
        err_d      = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                // busy stays high for the cycle in which done is shown and
                // drops afterwards unless a new job is accepted right away.
                if (start) begin
                    n_d      = DATA_W'(n);
                    result_d = {RES_W{1'b0}};
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    if (n_too_big_s) begin
                        err_flag_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        err_flag_d = 1'b0;
                        state_d    = ST_CLEAR;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end

            ST_CLEAR: begin
                // Pops are decoded combinationally while the stack is not
                // empty; this state just waits for the drain to finish.
                if (stk_empty) begin
                    state_d = ST_PUSH_N;
                end else begin
                    state_d = ST_CLEAR;
                end
            end

            ST_PUSH_N: begin
                state_d = ST_EVAL;
            end

            ST_EVAL: begin
                if (stk_empty) begin
                    state_d = ST_DONE;
                end else if (is_leaf_s) begin
                    result_d = sum_s[RES_W-1:0];
                    if (sum_s[RES_W]) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    state_d = ST_EVAL;
                end else begin
                    // Internal node: remember it so PUSH1/PUSH2 can push its
                    // two children.
                    x_d     = stk_dout;
                    state_d = ST_PUSH1;
                end
            end

            ST_PUSH1: begin
                state_d = ST_PUSH2;
            end

            ST_PUSH2: begin
                state_d = ST_EVAL;
            end

            ST_DONE: begin
                done_d  = 1'b1;
                err_d   = err_flag_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs; the stack is not reset here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            n_q        <= {DATA_W{1'b0}};
            x_q        <= {DATA_W{1'b0}};
            result_q   <= {RES_W{1'b0}};
            ovf_q      <= 1'b0;
            err_flag_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            x_q        <= x_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            err_flag_q <= err_flag_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Stack lane decode from the current state and the held node value.
    // Push states and pop states are disjoint, so push and pop are exclusive.
    always_comb begin
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_din  = {DATA_W{1'b0}};
        case (state_q)
            ST_CLEAR: begin
                stk_pop = ~stk_empty;
            end
            ST_PUSH_N: begin
                stk_push = 1'b1;
                stk_din  = n_q;
            end
            ST_EVAL: begin
                stk_pop = ~stk_empty;
            end
            ST_PUSH1: begin
                stk_push = 1'b1;
                stk_din  = x_q - DATA_W'(1);
            end
            ST_PUSH2: begin
                stk_push = 1'b1;
                stk_din  = x_q - DATA_W'(2);
            end
            default: begin
                stk_push = 1'b0;
                stk_pop  = 1'b0;
                stk_din  = {DATA_W{1'b0}};
            end
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign ovf    = ovf_q;
    assign result = result_q;

endmodule : fib_stack_ctrl

// File: tb/tb_fib_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fib_stack_ctrl
// Two controllers (RES_W=16 and RES_W=8), each beside a behavioural 256-deep
// LIFO without reset. Expectations come from a Fibonacci model and the
// latency formula 4*Fib(n+1)+1+k and are queued at stimulus time, then
// popped and compared when done is seen.
// -----------------------------------------------------------------------------
module tb_fib_stack_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance 0: default widths
    logic        start0;
    logic [4:0]  n0;
    logic        busy0, done0, err0, ovf0;
    logic [15:0] result0;
    logic        push0, pop0, empty0;
    logic [7:0]  din0, dout0;

    // Instance 1: 8-bit result
    logic        start1;
    logic [4:0]  n1;
    logic        busy1, done1, err1, ovf1;
    logic [7:0]  result1;
    logic        push1, pop1, empty1;
    logic [7:0]  din1, dout1;

    fib_stack_ctrl #(.DATA_W(8), .N_W(5), .RES_W(16), .N_MAX(24)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .n(n0),
        .busy(busy0), .done(done0), .err(err0), .ovf(ovf0), .result(result0),
        .stk_push(push0), .stk_pop(pop0), .stk_din(din0),
        .stk_dout(dout0), .stk_empty(empty0)
    );

    fib_stack_ctrl #(.DATA_W(8), .N_W(5), .RES_W(8), .N_MAX(24)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .n(n1),
        .busy(busy1), .done(done1), .err(err1), .ovf(ovf1), .result(result1),
        .stk_push(push1), .stk_pop(pop1), .stk_din(din1),
        .stk_dout(dout1), .stk_empty(empty1)
    );

    // Behavioural stacks: no reset, contents survive controller reset
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    int sp0 = 0;
    int sp1 = 0;
    int act0 = 0;
    logic [7:0] push_log [$];

    always @(posedge clk) begin
        if (push0) begin
            mem0[sp0] <= din0;
            sp0 <= sp0 + 1;
        end else if (pop0) begin
            sp0 <= sp0 - 1;
        end
        if (push0 || pop0) act0 <= act0 + 1;
    end

    always @(posedge clk) begin
        if (push0) push_log.push_back(din0);
    end

    always @(posedge clk) begin
        if (push1) begin
            mem1[sp1] <= din1;
            sp1 <= sp1 + 1;
        end else if (pop1) begin
            sp1 <= sp1 - 1;
        end
    end

    assign dout0  = (sp0 > 0) ? mem0[sp0-1] : 8'h00;
    assign empty0 = (sp0 == 0);
    assign dout1  = (sp1 > 0) ? mem1[sp1-1] : 8'h00;
    assign empty1 = (sp1 == 0);

    int vectors = 0;
    int miscompares = 0;

    // Push and pop must never coincide on either stack
    always @(negedge clk) begin
        assert (!(push0 && pop0)) else begin
            miscompares++;
            $error("FAIL mutex0 observed push=%0b pop=%0b expected not both", push0, pop0);
        end
        assert (!(push1 && pop1)) else begin
            miscompares++;
            $error("FAIL mutex1 observed push=%0b pop=%0b expected not both", push1, pop1);
        end
    end

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic        err;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb [$];

    function automatic longint fib(int m);
        longint a = 0;
        longint b = 1;
        longint t;
        for (int i = 0; i < m; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Run one job to completion on instance inst; k is the number of stale
    // stack entries. If pulse_at > 0, a spurious start is pulsed at that cycle.
    task automatic run_job(int inst, logic [4:0] nv, int k, string tag, int pulse_at);
        exp_t   e;
        exp_t   g;
        longint f;
        longint w;
        int     cyc;
        logic   d;
        w     = (inst == 0) ? 65536 : 256;
        f     = fib(int'(nv));
        e.tag = tag;
        e.err = (nv > 5'd24);
        e.res = e.err ? 16'd0 : 16'(f % w);
        e.ovf = !e.err && (f >= w);
        e.lat = e.err ? 1 : int'(4 * fib(int'(nv) + 1)) + 1 + k;
        sb.push_back(e);

        if (inst == 0) begin start0 = 1'b1; n0 = nv; end
        else           begin start1 = 1'b1; n1 = nv; end
        @(posedge clk);
        #1;
        start0 = 1'b0; n0 = 5'd0;
        start1 = 1'b0; n1 = 5'd0;

        cyc = 0;
        d   = 1'b0;
        while (!d && cyc < 60000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == pulse_at) begin
                if (inst == 0) begin start0 = 1'b1; n0 = 5'd3; end
                else           begin start1 = 1'b1; n1 = 5'd3; end
            end else begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            d = (inst == 0) ? done0 : done1;
        end

        g = sb.pop_front();
        check({g.tag, "_latency"}, 32'(cyc), 32'(g.lat));
        if (inst == 0) begin
            check({g.tag, "_result"}, 32'(result0), 32'(g.res));
            check({g.tag, "_err"},    32'(err0),    32'(g.err));
            check({g.tag, "_ovf"},    32'(ovf0),    32'(g.ovf));
            check({g.tag, "_busy"},   32'(busy0),   32'd1);
        end else begin
            check({g.tag, "_result"}, 32'(result1), 32'(g.res));
            check({g.tag, "_err"},    32'(err1),    32'(g.err));
            check({g.tag, "_ovf"},    32'(ovf1),    32'(g.ovf));
            check({g.tag, "_busy"},   32'(busy1),   32'd1);
        end
    endtask

    // Start a job on instance 0 and reset the controller after 'cycles' edges
    task automatic abort_job(logic [4:0] nv, int cycles, string tag);
        start0 = 1'b1;
        n0     = nv;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        n0     = 5'd0;
        @(posedge clk);
        #1;
        check({tag, "_no_early_done"}, 32'(done0), 32'd0);
        check({tag, "_busy"},          32'(busy0), 32'd1);
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_busy"},   32'(busy0),   32'd0);
        check({tag, "_rst_result"}, 32'(result0), 32'd0);
        check({tag, "_rst_push"},   32'(push0),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int act_before;
    int k;

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0; n0 = 5'd0;
        start1 = 1'b0; n1 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy0),   32'd0);
        check("rst_done",   32'(done0),   32'd0);
        check("rst_err",    32'(err0),    32'd0);
        check("rst_ovf",    32'(ovf0),    32'd0);
        check("rst_result", 32'(result0), 32'd0);
        check("rst_push",   32'(push0),   32'd0);
        check("rst_pop",    32'(pop0),    32'd0);
        check("rst_din",    32'(din0),    32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_job(0, 5'd0, 0, "n0", 0);

        push_log.delete();
        run_job(0, 5'd2, 0, "n2", 0);
        check("n2_push_count", 32'(push_log.size()), 32'd3);
        if (push_log.size() == 3) begin
            check("n2_push0", 32'(push_log[0]), 32'd2);
            check("n2_push1", 32'(push_log[1]), 32'd1);
            check("n2_push2", 32'(push_log[2]), 32'd0);
        end

        run_job(0, 5'd10, 0, "n10", 0);

        act_before = act0;
        run_job(0, 5'd25, 0, "n25_err", 0);
        check("n25_no_stack_activity", 32'(act0), 32'(act_before));

        run_job(0, 5'd20, 0, "n20", 0);

        abort_job(5'd24, 60, "n24_abort");
        abort_job(5'd10, 120, "n10_abort");
        k = sp0;
        check("residual_present", 32'(k > 0), 32'd1);
        run_job(0, 5'd5, k, "n5_after_reset", 0);
        check("stack_drained", 32'(sp0), 32'd0);

        run_job(1, 5'd14, 0, "n14_w8", 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fib_stack_ctrl
